wta_inhibit: RTL and testbench
==============================

WTA_INHIBIT -- requirements
Module: wta_inhibit

Interface
REQ-001: Parameter NEUR, default 16: number of competing neuron outputs in one column; legal range 2..64.
REQ-002: Parameter WRES, default 3: weight resolution; the spike pulse width is P = 2^WRES cycles.
REQ-003: clk  input  1  unit clock for temporal encoding; the only clock.
REQ-004: rstb  input  1  system reset, synchronous and active-low.
REQ-005: grst  input  1  one-cycle gamma clock pulse marking the start of a new gamma cycle.
REQ-006: spike_in  input  NEUR  P-cycle-wide output-spike pulses from the column's neuron bodies.
REQ-007: spike_out  output  NEUR  inhibited spikes; at most one bit high per gamma cycle; registered.
REQ-008: winner_idx  output  max(1,$clog2(NEUR))  index of the current gamma cycle's winner; registered.
REQ-009: winner_valid  output  1  high from winner latch until the next grst or reset.

Function
REQ-010: A spike event on bit i SHALL be a rising edge, meaning spike_in[i]=1 while prev[i]=0, where prev is a registered copy of spike_in.
REQ-011: The FSM SHALL have three states. IDLE means no winner yet. FIRE means the winner pulse is being emitted. LOCK means the winner pulse is done and everything is blocked until grst.
REQ-012: In IDLE with at least one event, the FSM SHALL latch the lowest-index event as winner, set winner_idx and winner_valid, and go to FIRE.
REQ-013: In FIRE, spike_out SHALL be one-hot at the winner for exactly P consecutive cycles. The first of those cycles is the cycle after the edge, so latency is 1.
REQ-014: The FIRE pulse SHALL be regenerated from an internal WRES-bit down-counter. Input pulse length or truncation SHALL NOT affect it.
REQ-015: After P cycles in FIRE, the FSM SHALL go to LOCK with spike_out=0.
REQ-016: Events arriving in FIRE or LOCK, including a repeat edge from the winner, SHALL be ignored.
REQ-017: grst SHALL force IDLE on the next cycle. It clears spike_out, winner_valid and winner_idx, even mid-FIRE, which truncates the pulse.
REQ-018: Events in the same cycle as grst SHALL be ignored. The new gamma cycle begins the following cycle.
REQ-019: When grst and rstb=0 coincide, reset SHALL take precedence; the outcome is identical in both cases.
REQ-020: A spike_in bit already high at reset release SHALL NOT count as an event until it falls and rises again.
REQ-021: The FSM SHALL never be in an illegal state. Any unused encoding SHALL return to IDLE on the next clock.

Reset
REQ-022: On rstb=0 at a clock edge, the following SHALL hold:
- state = IDLE
- spike_out = 0
- winner_idx = 0
- winner_valid = 0
- pulse counter = 0
- prev = all ones
REQ-023: Reset SHALL be synchronous only, with no asynchronous path. Outputs SHALL hold their reset values while rstb=0.

Configuration
REQ-024: Macro WTA_TIE_DROP_EN SHALL select tie handling.
REQ-025: With WTA_TIE_DROP_EN defined, two or more events in the same IDLE cycle SHALL produce no winner. The FSM goes straight to LOCK with winner_valid=0 and no spike_out for that gamma cycle.
REQ-026: Without WTA_TIE_DROP_EN, ties SHALL resolve to the lowest index per REQ-012.

Verification (NEUR=16, WRES=3, P=8)
REQ-027: Single winner. Pulse on spike_in[5] rising at cycle 10, other inputs quiet:
- spike_out=16'h0020 for cycles 11-18;
- winner_idx=5 and winner_valid=1 from cycle 11;
- spike_out=0 from cycle 19.
REQ-028: Late loser. spike_in[5] rises at cycle 10 and spike_in[2] rises at cycle 12: spike_out[2] stays 0 throughout and winner_idx stays 5.
REQ-029: Tie. spike_in[9] and spike_in[3] rise together at cycle 10:
- without the macro, winner_idx=3 and spike_out=16'h0008 for cycles 11-18;
- with WTA_TIE_DROP_EN, spike_out=0 and winner_valid=0 for the whole gamma cycle.
REQ-030: Gamma boundary.
- Winner 5 at cycle 10 and grst at cycle 14: spike_out=0 from cycle 15 and winner_valid=0.
- Then spike_in[7] rises at cycle 16: winner_idx=7 from cycle 17.
REQ-031: Edge coincident with grst. spike_in[4] rises in the same cycle as grst: no winner, and winner_valid stays 0.
REQ-032: Reset mid-operation.
- rstb=0 during FIRE: all outputs are 0 the next cycle.
- spike_in[1] is held high across reset release: no winner until it toggles low then high.

Source files
------------

// File: rtl/wta_inhibit.sv
// Winner-take-all lateral inhibition for one column: the first spike edge in a gamma cycle wins,
// and the winner gets a fresh 2^WRES-cycle pulse. Optional macro WTA_TIE_DROP_EN discards simultaneous ties.
module wta_inhibit #(
    parameter  int NEUR = 16,
    parameter  int WRES = 3,
    localparam int IW   = $clog2(NEUR)
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            grst,
    input  logic [NEUR-1:0] spike_in,
    output logic [NEUR-1:0] spike_out,
    output logic [IW-1:0]   winner_idx,
    output logic            winner_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FIRE = 2'b01,
        LOCK = 2'b10
    } state_t;

    state_t          state;
    logic [WRES-1:0] cnt;
    logic [NEUR-1:0] prev;
    logic [NEUR-1:0] events;
    logic [IW-1:0]   first_idx;
    logic            any_event;

    // NOTE: every comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        events    = spike_in & ~prev;
        first_idx = '0;
        for (int i = NEUR - 1; i >= 0; i--) begin
            if (events[i]) first_idx = IW'(i);
        end
    end

    assign any_event = |events;

`ifdef WTA_TIE_DROP_EN
    logic multi_event;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_event = |(events & (events - NEUR'(1)));
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state        <= IDLE;
            spike_out    <= '0;
            winner_idx   <= '0;
            winner_valid <= 1'b0;
            cnt          <= '0;
            prev         <= '1;   // inputs high at release must fall before they count
        end else begin
            prev <= spike_in;
            if (grst) begin
                state        <= IDLE;
                spike_out    <= '0;
                winner_idx   <= '0;
                winner_valid <= 1'b0;
                cnt          <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (any_event) begin
`ifdef WTA_TIE_DROP_EN
                            if (multi_event) begin
                                state <= LOCK;
                            end else
`endif
                            begin
                                state        <= FIRE;
                                spike_out    <= NEUR'(1) << first_idx;
                                winner_idx   <= first_idx;
                                winner_valid <= 1'b1;
                                cnt          <= {WRES{1'b1}};
                            end
                        end
                    end
                    FIRE: begin
                        // Pulse width comes only from the counter, never from the input pulse.
                        if (cnt == '0) begin
                            state     <= LOCK;
                            spike_out <= '0;
                        end else begin
                            cnt <= cnt - WRES'(1);
                        end
                    end
                    LOCK: begin
                        state <= LOCK;
                    end
                    default: begin
                        state        <= IDLE;
                        spike_out    <= '0;
                        winner_idx   <= '0;
                        winner_valid <= 1'b0;
                        cnt          <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wta_inhibit.sv
// Self-checking bench for wta_inhibit: directed scenarios plus random traffic against a
// timeline-based reference model (winner chosen per gamma cycle, pulse visible for P cycles).
module tb_wta_inhibit;

    localparam int NEUR = 16;
    localparam int WRES = 3;
    localparam int P    = 1 << WRES;
    localparam int IW   = $clog2(NEUR);

    logic            clk = 1'b0;
    logic            rstb;
    logic            grst;
    logic [NEUR-1:0] spike_in;
    logic [NEUR-1:0] spike_out;
    logic [IW-1:0]   winner_idx;
    logic            winner_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: previous inputs, decision for this gamma cycle, and the edge it happened on.
    logic [NEUR-1:0] m_prev;
    int              m_win;
    bit              m_done;
    int              m_start;
    int              m_edge;

    wta_inhibit #(.NEUR(NEUR), .WRES(WRES)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .grst         (grst),
        .spike_in     (spike_in),
        .spike_out    (spike_out),
        .winner_idx   (winner_idx),
        .winner_valid (winner_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic g, input logic [NEUR-1:0] s);
        logic [NEUR-1:0] ev;
        m_edge++;
        if (!r) begin
            m_prev = '1;
            m_win  = -1;
            m_done = 1'b0;
        end else begin
            ev     = s & ~m_prev;
            m_prev = s;
            if (g) begin
                m_win  = -1;
                m_done = 1'b0;
            end else if (!m_done && ev != '0) begin
                m_done  = 1'b1;
                m_win   = -1;
                m_start = m_edge;
`ifdef WTA_TIE_DROP_EN
                if ($countones(ev) < 2)
`endif
                for (int i = 0; i < NEUR; i++) begin
                    if (ev[i]) begin
                        m_win = i;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NEUR-1:0] eso;
        eso = '0;
        if (m_win >= 0 && (m_edge - m_start) < P) eso[m_win] = 1'b1;
        check({tag, ".spike_out"}, 64'(spike_out), 64'(eso));
        check({tag, ".winner_idx"}, 64'(winner_idx), (m_win >= 0) ? 64'(m_win) : 64'd0);
        check({tag, ".winner_valid"}, 64'(winner_valid), (m_win >= 0) ? 64'd1 : 64'd0);
    endtask

    task automatic cycle(input logic r, input logic g, input logic [NEUR-1:0] s, input string tag);
        rstb     = r;
        grst     = g;
        spike_in = s;
        @(posedge clk);
        model_edge(r, g, s);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [NEUR-1:0] rs;
        m_prev  = '1;
        m_win   = -1;
        m_done  = 1'b0;
        m_start = 0;
        m_edge  = 0;

        // Reset, including reset coinciding with grst and active inputs.
        cycle(1'b0, 1'b0, '0, "reset");
        cycle(1'b0, 1'b1, '1, "reset_grst");
        check("rst_so", 64'(spike_out), 64'd0);
        check("rst_valid", 64'(winner_valid), 64'd0);
        check("rst_idx", 64'(winner_idx), 64'd0);
        repeat (3) cycle(1'b1, 1'b0, '0, "quiet");

        // Single winner on bit 5, 8-cycle pulse then locked.
        cycle(1'b1, 1'b0, 16'h0020, "w5");
        check("w5_first_so", 64'(spike_out), 64'h0020);
        check("w5_idx", 64'(winner_idx), 64'd5);
        repeat (7) cycle(1'b1, 1'b0, 16'h0020, "w5_fire");
        check("w5_last_so", 64'(spike_out), 64'h0020);
        cycle(1'b1, 1'b0, '0, "w5_end");
        check("w5_lock_so", 64'(spike_out), 64'd0);
        check("w5_lock_valid", 64'(winner_valid), 64'd1);
        cycle(1'b1, 1'b0, 16'h0020, "w5_repeat");
        check("w5_repeat_so", 64'(spike_out), 64'd0);

        // Late loser: bit 2 rises two cycles after bit 5.
        cycle(1'b1, 1'b1, '0, "g1");
        cycle(1'b1, 1'b0, 16'h0020, "l5");
        cycle(1'b1, 1'b0, 16'h0020, "l5b");
        repeat (9) cycle(1'b1, 1'b0, 16'h0024, "l2");
        check("late_idx", 64'(winner_idx), 64'd5);
        check("late_bit2", 64'(spike_out[2]), 64'd0);

        // Tie between bits 9 and 3.
        cycle(1'b1, 1'b0, '0, "t_clr");
        cycle(1'b1, 1'b1, '0, "g2");
        cycle(1'b1, 1'b0, 16'h0208, "tie");
`ifdef WTA_TIE_DROP_EN
        check("tie_so", 64'(spike_out), 64'd0);
        check("tie_valid", 64'(winner_valid), 64'd0);
`else
        check("tie_so", 64'(spike_out), 64'h0008);
        check("tie_idx", 64'(winner_idx), 64'd3);
`endif
        repeat (9) cycle(1'b1, 1'b0, 16'h0208, "tie_hold");

        // Gamma boundary mid-FIRE, then a fresh winner.
        cycle(1'b1, 1'b0, '0, "b_clr");
        cycle(1'b1, 1'b1, '0, "g3");
        cycle(1'b1, 1'b0, 16'h0020, "b5");
        repeat (3) cycle(1'b1, 1'b0, 16'h0020, "b5_fire");
        cycle(1'b1, 1'b1, 16'h0020, "b_grst");
        check("b_grst_so", 64'(spike_out), 64'd0);
        check("b_grst_valid", 64'(winner_valid), 64'd0);
        cycle(1'b1, 1'b0, 16'h0020, "b_idle");
        cycle(1'b1, 1'b0, 16'h00a0, "b7");
        check("b7_idx", 64'(winner_idx), 64'd7);
        check("b7_so", 64'(spike_out), 64'h0080);
        repeat (8) cycle(1'b1, 1'b0, 16'h00a0, "b7_fire");

        // Edge coincident with grst is ignored.
        cycle(1'b1, 1'b0, '0, "c_clr");
        cycle(1'b1, 1'b1, 16'h0010, "c_edge");
        repeat (3) cycle(1'b1, 1'b0, 16'h0010, "c_hold");
        check("coinc_valid", 64'(winner_valid), 64'd0);

        // Reset mid-FIRE; bit 1 held across release.
        cycle(1'b1, 1'b0, '0, "r_clr");
        cycle(1'b1, 1'b1, '0, "g4");
        cycle(1'b1, 1'b0, 16'h0002, "r1");
        cycle(1'b1, 1'b0, 16'h0002, "r1_fire");
        cycle(1'b0, 1'b0, 16'h0002, "r_mid");
        check("rmid_so", 64'(spike_out), 64'd0);
        check("rmid_valid", 64'(winner_valid), 64'd0);
        repeat (3) cycle(1'b1, 1'b0, 16'h0002, "r_held");
        check("rheld_valid", 64'(winner_valid), 64'd0);
        cycle(1'b1, 1'b0, '0, "r_low");
        cycle(1'b1, 1'b0, 16'h0002, "r_rise");
        check("rrise_idx", 64'(winner_idx), 64'd1);
        check("rrise_so", 64'(spike_out), 64'h0002);

        // Random traffic: sparse toggles, occasional gamma pulses and resets.
        rs = '0;
        repeat (3000) begin
            for (int i = 0; i < NEUR; i++) begin
                if ($urandom_range(0, 23) == 0) rs[i] = ~rs[i];
            end
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 24) == 0), rs, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
